// File: rtl/alu_secure_pipe.sv
// alu_secure_pipe: two-stage valid/ready ALU with status flags.
// Optional redundant shadow self-check with sticky alarm, enabled by ALU_SELFCHECK_EN.
module alu_secure_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic             negative,
    input  logic             dbg_flip,
    input  logic             alarm_clr,
    output logic             alarm,
    output logic [CNT_W-1:0] mismatch_cnt
);
    localparam int M = WIDTH - 1;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
                           XOR = 3'd4, SHL = 3'd5, SHR = 3'd6, PASSB = 3'd7;

    logic             v1_q, v2_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       op_q;
    logic             c_q, z_q, o_q, n_q;
    logic             adv1, adv2, load2, flip;
    logic [WIDTH:0]   sum_w, dif_w;
    logic [WIDTH-1:0] p_r, p_rf;
    logic             p_c, p_o, p_z, p_n;

    assign adv2     = !v2_q | out_ready;
    assign adv1     = !v1_q | adv2;
    assign in_ready = !rst_n | adv1;
    assign load2    = adv2 & v1_q;

    assign sum_w = {1'b0, a_q} + {1'b0, b_q};
    assign dif_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        p_r = '0;
        p_c = 1'b0;
        p_o = 1'b0;
        case (op_q)
            ADD: begin
                p_r = sum_w[M:0];
                p_c = sum_w[WIDTH];
                p_o = (a_q[M] == b_q[M]) & (p_r[M] != a_q[M]);
            end
            SUB: begin
                p_r = dif_w[M:0];
                p_c = dif_w[WIDTH];
                p_o = (a_q[M] != b_q[M]) & (p_r[M] != a_q[M]);
            end
            AND:   p_r = a_q & b_q;
            OR:    p_r = a_q | b_q;
            XOR:   p_r = a_q ^ b_q;
            SHL: begin
                p_r = {a_q[M-1:0], 1'b0};
                p_c = a_q[M];
                p_o = a_q[M] ^ a_q[M-1];
            end
            SHR: begin
                p_r = {1'b0, a_q[M:1]};
                p_c = a_q[0];
            end
            PASSB: p_r = b_q;
        endcase
    end

    assign p_rf = p_r ^ {{(WIDTH-1){1'b0}}, flip};
    assign p_z  = ~|p_rf;
    assign p_n  = p_rf[M];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            res_q <= '0;
            {c_q, z_q, o_q, n_q} <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) {a_q, b_q, op_q} <= {a, b, op};
            end
            if (adv2) v2_q <= v1_q;
            if (load2) begin
                res_q <= p_rf;
                {c_q, z_q, o_q, n_q} <= {p_c, p_z, p_o, p_n};
            end
        end
    end

    assign out_valid = v2_q;
    assign result    = res_q;
    assign {carry, zero, overflow, negative} = {c_q, z_q, o_q, n_q};

`ifdef ALU_SELFCHECK_EN
    logic [WIDTH-1:0] s_r;
    logic             s_c, s_o, mism, alarm_q, alarm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign flip = dbg_flip;

    // Shadow path: formulated independently (two's-complement add, majority carry).
    always_comb begin
        s_r = op_q == ADD ? a_q + b_q :
              op_q == SUB ? a_q + ~b_q + WIDTH'(1) :
              op_q == AND ? ~(~a_q | ~b_q) :
              op_q == OR  ? ~(~a_q & ~b_q) :
              op_q == XOR ? (a_q & ~b_q) | (~a_q & b_q) :
              op_q == SHL ? a_q << 1 :
              op_q == SHR ? a_q >> 1 : b_q;
        s_c = op_q == ADD ? (a_q[M] & b_q[M]) | ((a_q[M] | b_q[M]) & ~s_r[M]) :
              op_q == SUB ? a_q < b_q :
              op_q == SHL ? a_q[M] :
              op_q == SHR ? a_q[0] : 1'b0;
        s_o = op_q == ADD ? ~(a_q[M] ^ b_q[M]) & (a_q[M] ^ s_r[M]) :
              op_q == SUB ? (a_q[M] ^ b_q[M]) & (a_q[M] ^ s_r[M]) :
              op_q == SHL ? a_q[M] ^ a_q[M-1] : 1'b0;
    end

    assign mism = load2 & ({p_rf, p_c, p_o, p_z, p_n} != {s_r, s_c, s_o, s_r == '0, s_r[M]});

    always_comb begin
        alarm_d = mism | (alarm_q & ~alarm_clr);
        cnt_d   = mism ? (alarm_clr ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1))) :
                  (alarm_clr ? '0 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alarm        = alarm_q;
    assign mismatch_cnt = cnt_q;
`else
    logic unused_dbg;

    assign flip         = 1'b0;
    assign unused_dbg   = ^{dbg_flip, alarm_clr};
    assign alarm        = 1'b0;
    assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_secure_pipe.sv
// tb_alu_secure_pipe: directed + random checks of alu_secure_pipe against an arithmetic reference model.
module tb_alu_secure_pipe;
    typedef struct packed {
        logic [7:0] r;
        logic       c, z, o, n;
    } exp_t;

`ifdef ALU_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic       clk = 0, rst_n = 0, rst_req = 0;
    logic       in_valid = 0, out_ready = 0, dbg_flip = 0, alarm_clr = 0;
    logic [7:0] a = 0, b = 0;
    logic [2:0] op = 0;
    logic       in_ready, out_valid, carry, zero, overflow, negative, alarm;
    logic [7:0] result, mismatch_cnt;

    exp_t q[$];
    int   total = 0, bad = 0, popped = 0, p0;

    alu_secure_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .overflow(overflow),
        .negative(negative), .dbg_flip(dbg_flip), .alarm_clr(alarm_clr),
        .alarm(alarm), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int sgn(input int v);
        return v > 127 ? v - 256 : v;
    endfunction

    function automatic exp_t model(input int x, input int y, input int o, input bit f);
        int r, s;
        bit c, v;
        c = 0;
        v = 0;
        case (o)
            0: begin r = x + y; c = r > 255; r = r % 256; s = sgn(x) + sgn(y); v = s > 127 || s < -128; end
            1: begin r = (x - y + 256) % 256; c = x < y; s = sgn(x) - sgn(y); v = s > 127 || s < -128; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = (x * 2) % 256; c = x > 127; s = sgn(x) * 2; v = s > 127 || s < -128; end
            6: begin r = x / 2; c = x % 2; end
            default: r = y;
        endcase
        if (f) r = r ^ 1;
        return {8'(r), c, r == 0, v, r > 127};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] iop, input logic ordy,
                         input logic flip = 0, input logic clr = 0);
        @(negedge clk);
        rst_n = rst_req;
        in_valid = iv;
        a = ia;
        b = ib;
        op = iop;
        out_ready = ordy;
        dbg_flip = flip;
        alarm_clr = clr;
        #1;
        if (!rst_n) q.delete();
        else begin
            if (out_valid && !out_ready && q.size() != 0)
                chk("hold", 32'({result, carry, zero, overflow, negative}), 32'(q[0]));
            if (out_valid && out_ready) begin
                chk("no_stale", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("beat", 32'({result, carry, zero, overflow, negative}), 32'(q.pop_front()));
                    popped++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, op, flip & SC));
        end
    endtask

    initial begin
        cycle(0, 0, 0, 0, 0);
        cycle(1, 8'h12, 8'h34, 0, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_state", 32'({out_valid, result, carry, zero, overflow, negative, alarm, mismatch_cnt}), 0);
        rst_req = 1;

        cycle(1, 8'hFF, 8'h01, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("lat_n1", 32'(out_valid), 0);
        cycle(0, 0, 0, 0, 1);
        chk("lat_n2", 32'(out_valid), 1);
        chk("add_ff_01", 32'({result, carry, zero, overflow, negative}), 32'({8'h00, 4'b1100}));

        cycle(1, 8'h7F, 8'h01, 0, 1);
        cycle(1, 8'h00, 8'h01, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("add_7f_01", 32'({result, carry, zero, overflow, negative}), 32'({8'h80, 4'b0011}));
        cycle(0, 0, 0, 0, 1);
        chk("sub_00_01", 32'({result, carry, zero, overflow, negative}), 32'({8'hFF, 4'b1001}));

        cycle(1, 8'h81, 8'h03, 0, 0);
        chk("bp_rdy1", 32'(in_ready), 1);
        cycle(1, 8'h81, 8'h03, 4, 0);
        chk("bp_rdy2", 32'(in_ready), 1);
        cycle(1, 8'h81, 8'h03, 5, 0);
        chk("bp_full", 32'(in_ready), 0);
        cycle(1, 8'h81, 8'h03, 5, 0);
        chk("bp_full2", 32'(in_ready), 0);
        cycle(1, 8'h81, 8'h03, 5, 1);
        chk("bp_release", 32'(in_ready), 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("shl_81", 32'({result, carry, zero, overflow, negative}), 32'({8'h02, 4'b1010}));
        chk("bp_drained", 32'(q.size()), 0);

        p0 = popped;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1);
            chk("stream_rdy", 32'(in_ready), 1);
        end
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("stream_count", 32'(popped - p0), 16);
        chk("stream_alarm", 32'(alarm), 0);

        cycle(1, 8'h01, 8'h01, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("flip_res", 32'(result), SC ? 3 : 2);
        chk("flip_alarm", 32'(alarm), 32'(SC));
        chk("flip_cnt", 32'(mismatch_cnt), 32'(SC));
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("clr_state", 32'({alarm, mismatch_cnt}), 0);

        for (int i = 0; i < 260; i++)
            cycle(1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("sat_cnt", 32'(mismatch_cnt), SC ? 255 : 0);
        chk("sat_alarm", 32'(alarm), 32'(SC));

        cycle(1, 8'h05, 8'h06, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 1);
        chk("mism_wins_cnt", 32'(mismatch_cnt), 32'(SC));
        chk("mism_wins_alarm", 32'(alarm), 32'(SC));
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("clr2_state", 32'({alarm, mismatch_cnt}), 0);

        cycle(1, 8'h11, 8'h22, 0, 0);
        cycle(1, 8'h33, 8'h44, 1, 0);
        rst_req = 0;
        cycle(1, 8'h55, 8'h66, 2, 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        rst_req = 1;
        cycle(0, 0, 0, 0, 1);
        chk("mid_rst_state", 32'({out_valid, result, carry, zero, overflow, negative, alarm, mismatch_cnt}), 0);
        p0 = popped;
        cycle(1, 8'h10, 8'h20, 3, 1);
        cycle(0, 0, 0, 0, 1);
        chk("post_rst_empty", 32'(out_valid), 0);
        cycle(0, 0, 0, 0, 1);
        chk("post_rst_or", 32'({result, carry, zero, overflow, negative}), 32'({8'h30, 4'b0000}));
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("post_rst_count", 32'(popped - p0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
